shared_mem_arbiter: RTL

//  Shares one single-port data RAM between the two MIPS cores' MEM stages, replacing per-core RAM ports.
//  Per cycle: grants at most one access, with round-robin priority between cores.

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/shared_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and encodings for the dual-core shared data RAM arbiter.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned LOCK_MAX_DEF = 15;

    typedef enum logic {
        OWNER_C0 = 1'b0,
        OWNER_C1 = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } lock_state_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_C0) ? OWNER_C1 : OWNER_C0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the priority pointer register lives in the caller.
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  owner_e     ptr,
    output logic [1:0] gnt,
    output logic       contested,
    output owner_e     loser
);

    logic [1:0] eff;

    // Masked requests; on contention ptr names the winner and the other core becomes the loser.
    always_comb begin
        eff       = req & ~mask;
        gnt       = eff;
        contested = &eff;
        loser     = ptr;
        if (contested) begin
            gnt   = (ptr == OWNER_C0) ? 2'b01 : 2'b10;
            loser = other_owner(ptr);
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port data RAM between two MIPS MEM stages with round-robin grants.
// Optional atomic-lock FSM is built when ARB_LOCK_EN is defined.
module shared_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic              stall1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0]        req_v;
    logic [1:0]        mask;
    logic [1:0]        arb_gnt;
    logic              arb_contested;
    logic              forced_c;
    owner_e            arb_loser;
    owner_e            forced_ptr;
    owner_e            ptr_q;
    owner_e            ptr_eff;
    owner_e            sel;
    owner_e            sel_q;
    owner_e            owner_q;
    logic              rd_pend_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    lock_state_e      state_q;
    lock_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             open_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OPEN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold/release for this cycle: a released lock arbitrates as if OPEN.
    always_comb begin
        mask       = 2'b00;
        forced_c   = 1'b0;
        forced_ptr = OWNER_C0;
        open_c     = 1'b1;
        case (state_q)
            ST_LOCK0: begin
                if (lock0 && (cnt_q != CNT_W'(LOCK_MAX))) begin
                    mask   = 2'b10;
                    open_c = 1'b0;
                end else begin
                    forced_c   = (cnt_q == CNT_W'(LOCK_MAX));
                    forced_ptr = OWNER_C1;
                end
            end
            ST_LOCK1: begin
                if (lock1 && (cnt_q != CNT_W'(LOCK_MAX))) begin
                    mask   = 2'b01;
                    open_c = 1'b0;
                end else begin
                    forced_c   = (cnt_q == CNT_W'(LOCK_MAX));
                    forced_ptr = OWNER_C0;
                end
            end
            default: ;
        endcase
    end

    // Next lock state: only a granted access with its lock bit set enters a lock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (open_c) begin
            state_d = ST_OPEN;
            cnt_d   = '0;
            if (arb_gnt[0] && lock0) begin
                state_d = ST_LOCK0;
            end else if (arb_gnt[1] && lock1) begin
                state_d = ST_LOCK1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_c;

    assign mask       = 2'b00;
    assign forced_c   = 1'b0;
    assign forced_ptr = OWNER_C0;
    assign unused_c   = ^{lock0, lock1, 32'(LOCK_MAX)};
`endif

    // No grants while reset is held, so the RAM is never touched during reset.
    assign req_v   = {req1, req0} & {2{~reset}};
    assign ptr_eff = forced_c ? forced_ptr : ptr_q;

    rr_arb2 u_rr_arb2 (
        .req       (req_v),
        .mask      (mask),
        .ptr       (ptr_eff),
        .gnt       (arb_gnt),
        .contested (arb_contested),
        .loser     (arb_loser)
    );

    assign gnt0   = arb_gnt[0];
    assign gnt1   = arb_gnt[1];
    assign stall0 = req0 & ~arb_gnt[0];
    assign stall1 = req1 & ~arb_gnt[1];

    // Mux select follows the winner and otherwise holds, keeping ram_addr/ram_din steady when idle.
    always_comb begin
        sel = sel_q;
        if (arb_gnt[1]) begin
            sel = OWNER_C1;
        end else if (arb_gnt[0]) begin
            sel = OWNER_C0;
        end
    end

    assign ram_en   = |arb_gnt;
    assign ram_we   = ram_en & ((sel == OWNER_C1) ? we1 : we0);
    assign ram_addr = (sel == OWNER_C1) ? addr1 : addr0;
    assign ram_din  = (sel == OWNER_C1) ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= OWNER_C0;
        end else if (arb_contested) begin
            ptr_q <= arb_loser;
        end else if (forced_c) begin
            ptr_q <= forced_ptr;
        end
    end

    // Owner tag travels with the grant; returned data is steered by it one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q     <= OWNER_C0;
            owner_q   <= OWNER_C0;
            rd_pend_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            sel_q     <= sel;
            owner_q   <= sel;
            rd_pend_q <= ram_en & ~ram_we;
            if (rvalid0) begin
                rdata0_q <= ram_dout;
            end
            if (rvalid1) begin
                rdata1_q <= ram_dout;
            end
        end
    end

    assign rvalid0 = rd_pend_q & (owner_q == OWNER_C0);
    assign rvalid1 = rd_pend_q & (owner_q == OWNER_C1);
    assign rdata0  = rvalid0 ? ram_dout : rdata0_q;
    assign rdata1  = rvalid1 ? ram_dout : rdata1_q;

endmodule
